// File: rtl/onehot_decoder_seq_pkg.sv
// onehot_decoder_seq_pkg: shared state encodings, widths and the index-to-one-hot helper
package onehot_decoder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int CNT_W  = 8;
    localparam int DATA_W = 3;
    localparam int OUT_W  = 8;

    function automatic logic [OUT_W-1:0] onehot(input logic [DATA_W-1:0] idx);
        return OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_decoder_fifo.sv
// onehot_decoder_fifo: DEPTH x 3-bit circular synchronous FIFO with occupancy count
module onehot_decoder_fifo
    import onehot_decoder_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       level_q, level_d;
    logic              do_push, do_pop;

    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];
    assign level   = level_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: queued 3:8 decoder driving each index as a timed one-hot strobe
module onehot_decoder_seq
    import onehot_decoder_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        A,
    input  logic                     A_valid,
    output logic                     A_ready,
    output logic [OUT_W-1:0]         Y,
    output logic                     Valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP   = GAP_CYCLES > 0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               valid_q, valid_d;
    logic               push, pop, full, empty;
    logic [DATA_W-1:0]  head;

    assign A_ready = !rst && !full;
    assign push    = A_valid && A_ready;
    assign Y       = y_q;
    assign Valid   = valid_q;

    onehot_decoder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (A),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    // One counter serves both hold and gap phases since they never overlap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (HAS_GAP) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else if (!empty) begin
                    pop   = 1'b1;
                    cnt_d = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d = state_d == ST_DRIVE;
        y_d     = pop ? onehot(head) : (valid_d ? y_q : '0);
    end

    assert property (@(posedge clk) disable iff (rst)
        !$isunknown(Y) && $onehot0(Y) && (Valid == (Y != '0)));

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: directed checks of the queued one-hot decoder in default and back-to-back configurations
module tb_onehot_decoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] a, b;
    logic       a_valid, b_valid, a_ready, b_ready, valid, b_vld;
    logic [7:0] y, b_y;
    logic [2:0] level, b_level;

    int checks = 0;
    int errors = 0;
    bit saw_full;
    logic [2:0] in_q [$];
    logic [2:0] exp_q [$];

    always #5 clk = ~clk;

    onehot_decoder_seq u_dut (
        .clk(clk), .rst(rst), .A(a), .A_valid(a_valid), .A_ready(a_ready),
        .Y(y), .Valid(valid), .level(level)
    );

    onehot_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b2b (
        .clk(clk), .rst(rst), .A(b), .A_valid(b_valid), .A_ready(b_ready),
        .Y(b_y), .Valid(b_vld), .level(b_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] penc(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Streams in_q into the default DUT and checks completed strobes against exp_q.
    task automatic run_stream(input int budget);
        logic [7:0] prev, e;
        int len, n;
        bit first, seen, done, xfer;
        prev = y; len = 0; first = 1; seen = 0; done = 0;
        for (n = 0; n < budget && !done; n++) begin
            a_valid = in_q.size() > 0;
            if (a_valid) a = in_q[0];
            chk("level_max", 32'(level <= 3'd4), 1);
            chk("ready_vs_level", 32'(a_ready), 32'(level != 3'd4));
            chk("valid_vs_y", 32'(valid), 32'(y != 8'h0));
            if (!a_ready) saw_full = 1;
            xfer = a_valid && a_ready;
            tick();
            if (xfer) void'(in_q.pop_front());
            if (y == prev) len++;
            else begin
                if (!first) begin
                    if (prev != 8'h0) begin
                        chk("strobe_expected", 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = 8'h1 << exp_q[0];
                            chk("strobe_value", 32'(prev), 32'(e));
                            chk("strobe_penc", 32'(penc(prev)), 32'(exp_q[0]));
                            void'(exp_q.pop_front());
                        end
                        chk("strobe_len", len, 4);
                        seen = 1;
                    end else if (seen) begin
                        chk("gap_len", len, 1);
                    end
                end
                first = 0; prev = y; len = 1;
            end
            done = exp_q.size() == 0 && in_q.size() == 0 && y == 8'h0 && level == 3'd0;
        end
        a_valid = 1'b0;
        chk("stream_done", 32'(done), 1);
    endtask

    initial begin
        rst = 1'b1; a = 3'd5; a_valid = 1'b1; b = 3'd5; b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_y", 32'(y), 0);
            chk("rst_valid", 32'(valid), 0);
            chk("rst_ready", 32'(a_ready), 0);
            chk("rst_level", 32'(level), 0);
            chk("rst_b_level", 32'(b_level), 0);
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("post_rst_level", 32'(level), 0);
        chk("post_rst_ready", 32'(a_ready), 1);
        chk("post_rst_y", 32'(y), 0);

        // single index 3 with default hold/gap
        a = 3'd3; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("single_level", 32'(level), 1);
        chk("single_y_early", 32'(y), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("single_y", 32'(y), 32'h08);
            chk("single_valid", 32'(valid), 1);
            tick();
        end
        chk("single_gap_y", 32'(y), 0);
        chk("single_gap_valid", 32'(valid), 0);
        tick();
        chk("single_idle_y", 32'(y), 0);
        chk("single_idle_level", 32'(level), 0);
        tick();

        // full sweep 0..7
        saw_full = 0;
        for (int i = 0; i < 8; i++) begin
            in_q.push_back(3'(i));
            exp_q.push_back(3'(i));
        end
        run_stream(120);
        chk("sweep_saw_full", 32'(saw_full), 1);
        tick(); tick();

        // back-to-back with HOLD=1, GAP=0
        b = 3'd6; b_valid = 1'b1;
        tick();
        chk("b2b_y0", 32'(b_y), 0);
        b = 3'd1;
        tick();
        chk("b2b_y_6", 32'(b_y), 32'h40);
        b = 3'd7;
        tick();
        b_valid = 1'b0;
        chk("b2b_y_1", 32'(b_y), 32'h02);
        tick();
        chk("b2b_y_7", 32'(b_y), 32'h80);
        chk("b2b_valid", 32'(b_vld), 1);
        tick();
        chk("b2b_end_y", 32'(b_y), 0);
        chk("b2b_end_level", 32'(b_level), 0);

        // full boundary
        a = 3'd1; a_valid = 1'b1;
        tick();
        a = 3'd4; tick();
        a = 3'd5; tick();
        a = 3'd6; tick();
        a = 3'd7; tick();
        chk("full_level", 32'(level), 4);
        chk("full_ready", 32'(a_ready), 0);
        chk("full_y", 32'(y), 32'h02);
        a = 3'd2;
        tick();
        chk("full_refused_level", 32'(level), 4);
        chk("full_refused_ready", 32'(a_ready), 0);
        chk("full_gap_y", 32'(y), 0);
        tick();
        chk("full_pop_level", 32'(level), 3);
        chk("full_pop_ready", 32'(a_ready), 1);
        chk("full_pop_y", 32'(y), 32'h10);
        in_q = {3'd2};
        exp_q = {3'd5, 3'd6, 3'd7, 3'd2};
        run_stream(80);
        tick(); tick();

        // reset mid-strobe with two entries queued
        a = 3'd4; a_valid = 1'b1;
        tick();
        a = 3'd0; tick();
        a = 3'd6; tick();
        a_valid = 1'b0;
        chk("mid_y", 32'(y), 32'h10);
        chk("mid_level", 32'(level), 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_y", 32'(y), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_ready", 32'(a_ready), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_stale_y", 32'(y), 0);
            chk("no_stale_level", 32'(level), 0);
        end
        a = 3'd3; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        chk("after_rst_y", 32'(y), 32'h08);
        chk("after_rst_valid", 32'(valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
